// File: rtl/processador_pkg.sv
// Shared definitions for the simple 9-bit processor: field widths, opcodes,
// bus source encodings, control FSM states and instruction field helpers.
package processador_pkg;

    localparam int OPW  = 3;
    localparam int REGW = 3;
    localparam int IW   = OPW + 2 * REGW;

    localparam logic [OPW-1:0] OP_MV  = 3'b000;
    localparam logic [OPW-1:0] OP_MVI = 3'b001;
    localparam logic [OPW-1:0] OP_ADD = 3'b010;
    localparam logic [OPW-1:0] OP_SUB = 3'b011;

    localparam logic [1:0] BUS_REG  = 2'b00;
    localparam logic [1:0] BUS_DIN  = 2'b01;
    localparam logic [1:0] BUS_G    = 2'b10;
    localparam logic [1:0] BUS_NONE = 2'b11;

    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } state_t;

    function automatic logic [OPW-1:0] ir_op(input logic [IW-1:0] ir);
        return ir[IW-1 -: OPW];
    endfunction

    function automatic logic [REGW-1:0] ir_x(input logic [IW-1:0] ir);
        return ir[2*REGW-1 -: REGW];
    endfunction

    function automatic logic [REGW-1:0] ir_y(input logic [IW-1:0] ir);
        return ir[REGW-1:0];
    endfunction

endpackage

// File: rtl/unidade_controle_if.sv
// Control unit bundle: run/din from the host side, datapath strobes back out.
// slave is the control unit's view, master the view of whoever drives run/din.
interface unidade_controle_if;
    import processador_pkg::*;

    logic            run;
    logic [IW-1:0]   din;
    logic            ir_in;
    logic [REGW-1:0] reg_in_sel;
    logic            reg_in_en;
    logic [REGW-1:0] reg_out_sel;
    logic [1:0]      bus_src;
    logic            a_in;
    logic            g_in;
    logic            addsub;
    logic            done;
    logic            busy;

    modport slave (
        input  run, din,
        output ir_in, reg_in_sel, reg_in_en, reg_out_sel, bus_src,
               a_in, g_in, addsub, done, busy
    );

    modport master (
        output run, din,
        input  ir_in, reg_in_sel, reg_in_en, reg_out_sel, bus_src,
               a_in, g_in, addsub, done, busy
    );
endinterface

// File: rtl/unidade_controle.sv
// Multi-cycle control FSM of the 9-bit processor. Latches the instruction in
// T0 and sequences bus select, register read/write selects and A/G/ALU
// strobes through T1..T3. Strobes decode combinationally from state and IR
// so they line up with the datapath edge that consumes them.
module unidade_controle
    import processador_pkg::*;
(
    input  logic               clock,
    input  logic               resetn,
    unidade_controle_if.slave  ctl
);

    state_t          state_r;
    logic [IW-1:0]   ir_r;

    logic            ir_in_s;
    logic [REGW-1:0] reg_in_sel_s;
    logic            reg_in_en_s;
    logic [REGW-1:0] reg_out_sel_s;
    logic [1:0]      bus_src_s;
    logic            a_in_s;
    logic            g_in_s;
    logic            addsub_s;
    logic            done_s;
    logic            busy_s;

    // State sequencing and instruction latch; run is only looked at in T0.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= T0;
            ir_r    <= {IW{1'b0}};
        end else begin
            case (state_r)
                T0: begin
                    if (ctl.run) begin
                        ir_r    <= ctl.din;
                        state_r <= T1;
                    end else begin
                        state_r <= T0;
                    end
                end
                T1: begin
                    if ((ir_op(ir_r) == OP_ADD) || (ir_op(ir_r) == OP_SUB)) begin
                        state_r <= T2;
                    end else begin
                        state_r <= T0;
                    end
                end
                T2:      state_r <= T3;
                T3:      state_r <= T0;
                default: state_r <= T0;
            endcase
        end
    end

    // Datapath strobe decode; idle bus and no strobes unless a step asks.
    always_comb begin
        ir_in_s       = 1'b0;
        reg_in_sel_s  = {REGW{1'b0}};
        reg_in_en_s   = 1'b0;
        reg_out_sel_s = {REGW{1'b0}};
        bus_src_s     = BUS_NONE;
        a_in_s        = 1'b0;
        g_in_s        = 1'b0;
        addsub_s      = 1'b0;
        done_s        = 1'b0;
        busy_s        = 1'b1;
        case (state_r)
            T0: begin
                busy_s = 1'b0;
                // Held low while reset is asserted so run cannot leak a strobe.
                if (ctl.run && resetn) begin
                    ir_in_s = 1'b1;
                end else begin
                    ir_in_s = 1'b0;
                end
            end
            T1: begin
                case (ir_op(ir_r))
                    OP_MV: begin
                        bus_src_s     = BUS_REG;
                        reg_out_sel_s = ir_y(ir_r);
                        reg_in_sel_s  = ir_x(ir_r);
                        reg_in_en_s   = 1'b1;
                        done_s        = 1'b1;
                    end
                    OP_MVI: begin
                        bus_src_s    = BUS_DIN;
                        reg_in_sel_s = ir_x(ir_r);
                        reg_in_en_s  = 1'b1;
                        done_s       = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        bus_src_s     = BUS_REG;
                        reg_out_sel_s = ir_x(ir_r);
                        a_in_s        = 1'b1;
                    end
                    default: begin
                        // Reserved opcodes retire as a one-cycle no-op.
                        done_s = 1'b1;
                    end
                endcase
            end
            T2: begin
                bus_src_s     = BUS_REG;
                reg_out_sel_s = ir_y(ir_r);
                g_in_s        = 1'b1;
                addsub_s      = ir_r[IW-OPW];
            end
            T3: begin
                bus_src_s    = BUS_G;
                reg_in_sel_s = ir_x(ir_r);
                reg_in_en_s  = 1'b1;
                done_s       = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign ctl.ir_in       = ir_in_s;
    assign ctl.reg_in_sel  = reg_in_sel_s;
    assign ctl.reg_in_en   = reg_in_en_s;
    assign ctl.reg_out_sel = reg_out_sel_s;
    assign ctl.bus_src     = bus_src_s;
    assign ctl.a_in        = a_in_s;
    assign ctl.g_in        = g_in_s;
    assign ctl.addsub      = addsub_s;
    assign ctl.done        = done_s;
    assign ctl.busy        = busy_s;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: a vector table of single instructions
// plus hand-written sequences for back-to-back issue and mid-instruction reset.
module tb_unidade_controle;

    logic clock;
    logic resetn;
    int   n_cmp;
    int   n_err;

    unidade_controle_if ifc();

    unidade_controle dut (
        .clock  (clock),
        .resetn (resetn),
        .ctl    (ifc.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {ir_in, reg_in_sel, reg_in_en, reg_out_sel, bus_src, a_in, g_in, addsub, done, busy}
    function automatic logic [14:0] o(input logic ir, input logic [2:0] rs, input logic re,
                                      input logic [2:0] ro, input logic [1:0] bs,
                                      input logic a, input logic g, input logic s,
                                      input logic d, input logic b);
        return {ir, rs, re, ro, bs, a, g, s, d, b};
    endfunction

    function automatic logic [14:0] outs();
        return {ifc.ir_in, ifc.reg_in_sel, ifc.reg_in_en, ifc.reg_out_sel, ifc.bus_src,
                ifc.a_in, ifc.g_in, ifc.addsub, ifc.done, ifc.busy};
    endfunction

    task automatic chk(input string nm, input logic [14:0] exp);
        logic [14:0] got;
        got = outs();
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b required %b", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [8:0]  instr;
        logic [8:0]  imm;
        int          ncyc;
        logic [14:0] e1;
        logic [14:0] e2;
        logic [14:0] e3;
    } vec_t;

    vec_t vt[7];

    logic [14:0] idle_o;
    logic [14:0] t0run_o;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        idle_o  = o(1'b0, 3'd0, 1'b0, 3'd0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        t0run_o = o(1'b1, 3'd0, 1'b0, 3'd0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        vt[0] = '{"mvi_r3", 9'b001_011_000, 9'd77, 1,
                  o(1'b0, 3'd3, 1'b1, 3'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 15'd0, 15'd0};
        vt[1] = '{"mv_r5_r2", 9'b000_101_010, 9'd0, 1,
                  o(1'b0, 3'd5, 1'b1, 3'd2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 15'd0, 15'd0};
        vt[2] = '{"sub_r1_r4", 9'b011_001_100, 9'h1ff, 3,
                  o(1'b0, 3'd0, 1'b0, 3'd1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1),
                  o(1'b0, 3'd0, 1'b0, 3'd4, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1),
                  o(1'b0, 3'd1, 1'b1, 3'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1)};
        vt[3] = '{"add_r7_r7", 9'b010_111_111, 9'd0, 3,
                  o(1'b0, 3'd0, 1'b0, 3'd7, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1),
                  o(1'b0, 3'd0, 1'b0, 3'd7, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1),
                  o(1'b0, 3'd7, 1'b1, 3'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1)};
        vt[4] = '{"rsv_110", 9'b110_010_011, 9'd0, 1,
                  o(1'b0, 3'd0, 1'b0, 3'd0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 15'd0, 15'd0};
        vt[5] = '{"rsv_100", 9'b100_111_001, 9'd0, 1,
                  o(1'b0, 3'd0, 1'b0, 3'd0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 15'd0, 15'd0};
        vt[6] = '{"mv_r2_r2", 9'b000_010_010, 9'd5, 1,
                  o(1'b0, 3'd2, 1'b1, 3'd2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 15'd0, 15'd0};

        // Power-on reset, with run high to show it cannot leak through.
        resetn   = 1'b0;
        ifc.run  = 1'b1;
        ifc.din  = 9'b010_001_001;
        step();
        step();
        chk("reset_hold", idle_o);
        ifc.run = 1'b0;
        #2 resetn = 1'b1;
        step();
        chk("post_reset_idle", idle_o);

        // Vector table: issue, walk each step, confirm return to idle.
        for (int i = 0; i < 7; i++) begin
            ifc.run = 1'b1;
            ifc.din = vt[i].instr;
            #1;
            chk({vt[i].name, "_t0"}, t0run_o);
            step();
            ifc.run = 1'b0;
            ifc.din = vt[i].imm;
            #1;
            chk({vt[i].name, "_t1"}, vt[i].e1);
            if (vt[i].ncyc == 3) begin
                step();
                chk({vt[i].name, "_t2"}, vt[i].e2);
                step();
                chk({vt[i].name, "_t3"}, vt[i].e3);
            end else begin
                chk({vt[i].name, "_t1_again"}, vt[i].e1);
            end
            step();
            chk({vt[i].name, "_idle"}, idle_o);
        end

        // Back-to-back add R3,R4 then mv R1,R3 with run held/toggled.
        ifc.run = 1'b1;
        ifc.din = 9'b010_011_100;
        step();
        chk("b2b_add_t1", o(1'b0, 3'd0, 1'b0, 3'd3, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        ifc.run = 1'b0;
        ifc.din = 9'b001_110_110;
        step();
        chk("b2b_add_t2", o(1'b0, 3'd0, 1'b0, 3'd4, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        ifc.run = 1'b1;
        step();
        ifc.din = 9'b000_001_011;
        #1;
        chk("b2b_add_t3", o(1'b0, 3'd3, 1'b1, 3'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        step();
        chk("b2b_gap_t0", t0run_o);
        step();
        ifc.run = 1'b0;
        #1;
        chk("b2b_mv_t1", o(1'b0, 3'd1, 1'b1, 3'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        step();
        chk("b2b_idle", idle_o);

        // Reset in the middle of an add's T2 step.
        ifc.run = 1'b1;
        ifc.din = 9'b010_110_001;
        step();
        ifc.run = 1'b0;
        step();
        chk("rst_pre_t2", o(1'b0, 3'd0, 1'b0, 3'd1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        #2;
        ifc.run = 1'b1;
        resetn  = 1'b0;
        #1;
        chk("rst_async", idle_o);
        ifc.run = 1'b0;
        step();
        step();
        #2 resetn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("rst_release_idle", idle_o);
        end
        ifc.run = 1'b1;
        ifc.din = 9'b000_100_110;
        step();
        ifc.run = 1'b0;
        #1;
        chk("rst_then_mv", o(1'b0, 3'd4, 1'b1, 3'd6, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        step();
        chk("rst_then_idle", idle_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Multi-cycle control FSM for the simple 9-bit processor.
- Latches an instruction word from din and sequences the datapath strobes: bus source select, register read select, A/G latch enables and add/sub.
- Also drives the 3-bit register-write address plus enable. The 3-to-8 one-hot decoder turns that address into the R0..R7 load strobes.
- Sits directly upstream of that decoder and of the bus multiplexer.

Parameters:
- OPW, 3, opcode field width (instruction bits [8:6]).
- REGW, 3, register address width (X field [5:3], Y field [2:0]); 2**REGW registers.
- IW, 9, instruction width; must equal OPW+2*REGW.

Ports:
- clock  in  1  single system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- run  in  1  start request; sampled only in state T0
- din  in  IW  instruction word (T0), immediate data (mvi in T1)
- ir_in  out  1  IR load strobe (debug/visibility)
- reg_in_sel  out  REGW  register write address, to 3-to-8 decoder
- reg_in_en  out  1  gates decoder outputs; register loads only when 1
- reg_out_sel  out  REGW  register driven onto bus when bus_src=00
- bus_src  out  2  00 register, 01 din, 10 G, 11 idle/none
- a_in  out  1  load A from bus
- g_in  out  1  load G from ALU
- addsub  out  1  0 add, 1 subtract (A ± bus)
- done  out  1  one-cycle pulse in the final step of each instruction
- busy  out  1  high in every state except T0

Behaviour:
- Reset (resetn=0, asynchronous, any state): state=T0, IR=0. All strobes 0, bus_src=11, selects 0, done=0, busy=0.
- IR register: loads din on the rising edge when in T0 and run=1. ir_in=1 combinationally in T0 when run=1.
- States T0, T1, T2, T3, 2-bit encoded. Outputs are combinational from state and IR; default is all strobes 0 and bus_src=11.
- T0: idle. run=1 → T1 next; else stay.
- T1 by opcode IR[8:6]:
  - 000 mv Rx,Ry: bus_src=00, reg_out_sel=Y, reg_in_sel=X, reg_in_en=1, done=1 → T0.
  - 001 mvi Rx,#D: bus_src=01 (din carries D this cycle), reg_in_sel=X, reg_in_en=1, done=1 → T0.
  - 010 add / 011 sub: bus_src=00, reg_out_sel=X, a_in=1 → T2.
  - 100..111 reserved: no strobes, done=1 → T0 (one-cycle no-op).
- T2 (add/sub): bus_src=00, reg_out_sel=Y, g_in=1, addsub=IR[6] → T3.
- T3: bus_src=10, reg_in_sel=X, reg_in_en=1, done=1 → T0.
- Latency, counted from the clock edge sampling run=1: mv/mvi/reserved done 1 cycle later; add/sub done 3 cycles later.
- Back-to-back operation: run held high re-samples in T0 the cycle after done, so there is always exactly one T0 cycle between instructions.
- run is ignored outside T0. din is ignored outside T0, except during mvi T1.
- X=Y is legal: add R1,R1 doubles R1; mv R2,R2 is a no-op write.
- reg_in_en is never 1 in T0 or T2. a_in and g_in are never 1 in the same cycle.
- Reset mid-instruction aborts it: no further strobes, no done pulse. After release, the FSM waits in T0 for run.

Decomposition:
- Shared package processador_pkg holds:
  - opcode constants OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011;
  - bus_src encodings BUS_REG, BUS_DIN, BUS_G, BUS_NONE;
  - state encodings T0..T3.
- No sub-module: single FSM plus IR. The 3-to-8 decoder stays an external sibling instance.

Test Plan:
- Reset: drive resetn=0 mid-T2 of an add → outputs immediately at reset values, state T0; after release with run=0, busy=0 and no strobes for 5 cycles.
- mvi: run=1, din=9'b001_011_000, then din=9'd77 → T1 shows bus_src=01, reg_in_sel=3, reg_in_en=1, done=1; busy falls next cycle.
- mv: din=9'b000_101_010 → T1 shows bus_src=00, reg_out_sel=2, reg_in_sel=5, reg_in_en=1, done=1, one cycle after run sampled.
- sub: din=9'b011_001_100 → T1 a_in=1, reg_out_sel=1; T2 g_in=1, addsub=1, reg_out_sel=4; T3 bus_src=10, reg_in_sel=1, reg_in_en=1, done=1; done at run-edge+3.
- Back-to-back: run held 1 with add then mv → exactly one T0 cycle between the done pulses; run toggled during T1..T3 has no effect.
- Reserved: opcode 3'b110 → done=1 in T1 with reg_in_en=0, a_in=0, g_in=0, bus_src=11.
